// File: rtl/gp_regfile_sb.sv
// General-purpose register file: two combinational read ports, one write port,
// optional write-to-read bypass, per-entry busy scoreboard and a post-reset clear sweep.
module gp_regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   input  logic [ADDR_W-1:0] read_idx_1,
   input  logic [ADDR_W-1:0] read_idx_2,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   output logic              read_busy_1,
   output logic              read_busy_2,
   input  logic [ADDR_W-1:0] write_idx,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] rsv_idx,
   input  logic              rsv_enable
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned NPORTS = 2;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] gp_q   [DEPTH];
   logic [DATA_W-1:0] gp_d   [DEPTH];
   logic              busy_q [DEPTH];
   logic              busy_d [DEPTH];

   logic              run;
   logic              we_ok;
   logic              rsv_ok;
   logic [ADDR_W-1:0] rd_idx  [NPORTS];
   logic [DATA_W-1:0] rd_data [NPORTS];
   logic              rd_busy [NPORTS];

   assign run    = (state_q == ST_RUN);
   // Writes/reservations are only honoured in RUN; entry 0 is dropped when hardwired.
   assign we_ok  = write_enable && run && !(ZERO_REG && (write_idx == '0));
   assign rsv_ok = rsv_enable   && run && !(ZERO_REG && (rsv_idx   == '0));

   // Sweep sequencing and array/scoreboard next-state
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gp_d    = gp_q;
      busy_d  = busy_q;
      case (state_q)
         ST_CLEAR: begin
            gp_d[ptr_q]   = '0;
            busy_d[ptr_q] = 1'b0;
            ptr_d         = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (we_ok) begin
               gp_d[write_idx]   = write_data;
               busy_d[write_idx] = 1'b0;
            end
            // Applied after the write so a same-index reservation wins
            if (rsv_ok) begin
               busy_d[rsv_idx] = 1'b1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
      ready_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ready_q <= ready_d;
         gp_q    <= gp_d;
         busy_q  <= busy_d;
      end
   end

   assign rd_idx[0] = read_idx_1;
   assign rd_idx[1] = read_idx_2;

   // Read ports: zero while clearing, forwarded write data on an index match
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (run && !(ZERO_REG && (rd_idx[p] == '0))) begin
            if (BYPASS && we_ok && (write_idx == rd_idx[p])) begin
               rd_data[p] = write_data;
               rd_busy[p] = 1'b0;
            end else begin
               rd_data[p] = gp_q[rd_idx[p]];
               rd_busy[p] = busy_q[rd_idx[p]];
            end
         end
      end
   end

   assign ready       = ready_q;
   assign read_data_1 = rd_data[0];
   assign read_data_2 = rd_data[1];
   assign read_busy_1 = rd_busy[0];
   assign read_busy_2 = rd_busy[1];

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Directed bench for gp_regfile_sb: one bypassing instance and one non-bypassing
// instance driven by the same stimulus.
module tb_gp_regfile_sb;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] read_idx_1, read_idx_2, write_idx, rsv_idx;
   logic [DATA_W-1:0] write_data;
   logic              write_enable, rsv_enable;

   logic              ready_b, busy1_b, busy2_b;
   logic [DATA_W-1:0] rd1_b, rd2_b;
   logic              ready_n, busy1_n, busy2_n;
   logic [DATA_W-1:0] rd1_n, rd2_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gp_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .ready(ready_b),
      .read_idx_1(read_idx_1), .read_idx_2(read_idx_2),
      .read_data_1(rd1_b), .read_data_2(rd2_b),
      .read_busy_1(busy1_b), .read_busy_2(busy2_b),
      .write_idx(write_idx), .write_data(write_data), .write_enable(write_enable),
      .rsv_idx(rsv_idx), .rsv_enable(rsv_enable)
   );

   gp_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .ready(ready_n),
      .read_idx_1(read_idx_1), .read_idx_2(read_idx_2),
      .read_data_1(rd1_n), .read_data_2(rd2_n),
      .read_busy_1(busy1_n), .read_busy_2(busy2_n),
      .write_idx(write_idx), .write_data(write_data), .write_enable(write_enable),
      .rsv_idx(rsv_idx), .rsv_enable(rsv_enable)
   );

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write_enable = 1'b0;
      rsv_enable   = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      read_idx_1 = '0; read_idx_2 = '0; write_idx = '0; rsv_idx = '0;
      write_data = '0; write_enable = 1'b0; rsv_enable = 1'b0;

      // 1: reset, then ready low for exactly 32 cycles, reads zero throughout
      tick(); tick();
      check("reset_ready", 32'(ready_b), 32'd0);
      reset = 1'b0;
      read_idx_1 = 5'd5; read_idx_2 = 5'd31;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (i == 16) begin
            check("clear_rd1_zero", rd1_b, 32'd0);
            check("clear_busy1_zero", 32'(busy1_b), 32'd0);
         end
         if (i == 31) check("ready_low_c31", 32'(ready_b), 32'd0);
         if (i == 32) check("ready_high_c32", 32'(ready_b), 32'd1);
      end
      check("nb_ready_c32", 32'(ready_n), 32'd1);
      #1;
      check("post_clear_rd1", rd1_b, 32'd0);
      check("post_clear_rd2", rd2_b, 32'd0);

      // 2: write idx5, bypass same cycle, array next cycle
      write_enable = 1'b1; write_idx = 5'd5; write_data = 32'hDEADBEEF; read_idx_1 = 5'd5;
      #1;
      check("byp_same_cycle", rd1_b, 32'hDEADBEEF);
      check("nobyp_same_cycle_old", rd1_n, 32'd0);
      tick(); idle(); #1;
      check("byp_next_cycle", rd1_b, 32'hDEADBEEF);
      check("nobyp_next_cycle", rd1_n, 32'hDEADBEEF);

      // 3: writes and reservations to entry 0 are dropped
      write_enable = 1'b1; write_idx = 5'd0; write_data = 32'h1234;
      rsv_enable = 1'b1; rsv_idx = 5'd0; read_idx_1 = 5'd0;
      #1;
      check("zero_rd_same", rd1_b, 32'd0);
      check("zero_busy_same", 32'(busy1_b), 32'd0);
      tick(); idle(); #1;
      check("zero_rd_next", rd1_b, 32'd0);
      check("zero_busy_next", 32'(busy1_b), 32'd0);
      check("zero_rd_next_nb", rd1_n, 32'd0);

      // 4: scoreboard on idx7
      rsv_enable = 1'b1; rsv_idx = 5'd7; read_idx_1 = 5'd7;
      #1;
      check("rsv_not_visible_same", 32'(busy1_b), 32'd0);
      tick(); idle(); #1;
      check("rsv_busy_next", 32'(busy1_b), 32'd1);
      write_enable = 1'b1; write_idx = 5'd7; write_data = 32'h77;
      rsv_enable = 1'b1; rsv_idx = 5'd7;
      #1;
      check("wr_rsv_same_byp_busy", 32'(busy1_b), 32'd0);
      check("wr_rsv_same_nb_busy", 32'(busy1_n), 32'd1);
      tick(); idle(); #1;
      check("rsv_wins_busy", 32'(busy1_b), 32'd1);
      check("rsv_wins_busy_nb", 32'(busy1_n), 32'd1);
      check("rsv_wins_data", rd1_b, 32'h77);
      write_enable = 1'b1; write_idx = 5'd7; write_data = 32'h88;
      #1;
      check("wr_only_byp_busy", 32'(busy1_b), 32'd0);
      check("wr_only_nb_busy", 32'(busy1_n), 32'd1);
      tick(); idle(); #1;
      check("wr_only_busy_cleared", 32'(busy1_b), 32'd0);
      check("wr_only_busy_cleared_nb", 32'(busy1_n), 32'd0);
      check("wr_only_data", rd1_b, 32'h88);

      // Different indices same cycle: write clears 7-none, reservation sets 8
      write_enable = 1'b1; write_idx = 5'd7; write_data = 32'h99;
      rsv_enable = 1'b1; rsv_idx = 5'd8; read_idx_2 = 5'd8;
      tick(); idle(); #1;
      check("diff_idx_busy8", 32'(busy2_b), 32'd1);
      check("diff_idx_busy7", 32'(busy1_b), 32'd0);
      check("diff_idx_data7", rd1_b, 32'h99);

      // 6: both ports bypass the same write
      read_idx_1 = 5'd9; read_idx_2 = 5'd9;
      write_enable = 1'b1; write_idx = 5'd9; write_data = 32'h55;
      #1;
      check("dual_byp_rd1", rd1_b, 32'h55);
      check("dual_byp_rd2", rd2_b, 32'h55);
      check("dual_nb_rd2_old", rd2_n, 32'd0);
      tick(); idle(); #1;
      check("dual_next_rd2_nb", rd2_n, 32'h55);

      // 5: reset mid-sweep restarts the full 32-cycle clear
      write_enable = 1'b1; write_idx = 5'd3; write_data = 32'hA5A5A5A5;
      tick(); idle();
      read_idx_1 = 5'd3; read_idx_2 = 5'd8;
      #1;
      check("idx3_written", rd1_b, 32'hA5A5A5A5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) tick();
      check("mid_sweep_ready", 32'(ready_b), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         if (i == 20) begin
            write_enable = 1'b1; write_idx = 5'd3; write_data = 32'hFFFF0000;
            rsv_enable = 1'b1; rsv_idx = 5'd3;
         end
         tick();
         idle();
         if (i == 31) check("resweep_ready_low_c31", 32'(ready_b), 32'd0);
         if (i == 32) check("resweep_ready_high_c32", 32'(ready_b), 32'd1);
      end
      #1;
      check("resweep_idx3_zero", rd1_b, 32'd0);
      check("resweep_idx3_busy", 32'(busy1_b), 32'd0);
      check("resweep_idx8_busy", 32'(busy2_b), 32'd0);
      check("resweep_idx3_zero_nb", rd1_n, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
